// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter:
// starvation limit default, FSM encodings, zero-register constant, queue entry.
package wb_arbiter_pkg;

   localparam int STARVE_LIM_DEF = 4;

   localparam logic [4:0] ZERO_REG = 5'd0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wbq_ent_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the WB stage / MDU / hazard unit and the arbiter.
// The slave modport is the arbiter side.
interface wb_arbiter_if;

   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic [4:0]  q_addr;
   logic        q_hit;
   logic        stall;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   modport master (
      output pipe_we, pipe_rd, pipe_data,
      output mdu_valid, mdu_rd, mdu_data,
      output q_addr,
      input  mdu_ready, q_hit, stall,
      input  rf_we, rf_wa, rf_wd
   );

   modport slave (
      input  pipe_we, pipe_rd, pipe_data,
      input  mdu_valid, mdu_rd, mdu_data,
      input  q_addr,
      output mdu_ready, q_hit, stall,
      output rf_we, rf_wa, rf_wd
   );

endinterface

// File: rtl/wbq_fifo.sv
// Two-entry MDU result queue, kept compacted so slot 0 is always the head.
// Supports invalidate-by-rd and a register lookup for the hazard unit.
module wbq_fifo
   import wb_arbiter_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           enq,
   input  wbq_ent_t       enq_ent,
   input  logic           deq,
   input  logic           inv_en,
   input  logic [4:0]     inv_rd,
   input  logic [4:0]     q_addr,
   output logic           q_hit,
   output wbq_ent_t       head,
   output logic           head_inv,
   output logic [1:0]     count,
   output logic           empty_nxt
);

   wbq_ent_t [1:0] ent_q, ent_d;
   logic [1:0]     vld_q, vld_d;

   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (deq) begin
         ent_d[0] = ent_q[1];
         vld_d    = {1'b0, vld_q[1]};
      end
      if (inv_en) begin
         for (int i = 0; i < 2; i++) begin
            if (vld_d[i] && ent_d[i].rd == inv_rd) vld_d[i] = 1'b0;
         end
      end
      // close any hole left by invalidation before appending
      if (!vld_d[0]) begin
         ent_d[0] = ent_d[1];
         vld_d    = {1'b0, vld_d[1]};
      end
      if (enq) begin
         if (!vld_d[0]) begin
            ent_d[0] = enq_ent;
            vld_d[0] = 1'b1;
         end else begin
            ent_d[1] = enq_ent;
            vld_d[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q <= '0;
         vld_q <= '0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   always_comb begin
      q_hit = 1'b0;
      if (q_addr != ZERO_REG) begin
         for (int i = 0; i < 2; i++) begin
            if (vld_q[i] && ent_q[i].rd == q_addr) q_hit = 1'b1;
         end
      end
   end

   assign head      = ent_q[0];
   assign head_inv  = inv_en && vld_q[0] && ent_q[0].rd == inv_rd;
   assign count     = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
   assign empty_nxt = ~vld_d[0];

endmodule

// File: rtl/wb_arbiter.sv
// Owns the single register-file write port, sharing it between the WB
// stage and queued MDU results, with a one-cycle stall on starvation.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIM = STARVE_LIM_DEF
)(
   input  logic          clk,
   input  logic          rst,
   wb_arbiter_if.slave   bus
);

   localparam logic [2:0] LIM3 = 3'(STARVE_LIM);

   logic [1:0]  state_q, state_d;
   logic [2:0]  age_q, age_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_wa_q, rf_wa_d;
   logic [31:0] rf_wd_q, rf_wd_d;

   logic        pipe_v, stall, head_v, mdu_ready, enq;
   logic        gnt_pipe, gnt_head;
   logic        head_inv, empty_nxt, q_hit;
   logic [1:0]  count;
   wbq_ent_t    head, enq_ent;

   assign pipe_v    = bus.pipe_we && bus.pipe_rd != ZERO_REG;
   assign stall     = state_q == ST_FORCE;
   assign head_v    = count != 2'd0;
   assign mdu_ready = count != 2'd2;
   assign enq       = bus.mdu_valid && mdu_ready && bus.mdu_rd != ZERO_REG;
   assign enq_ent   = '{rd: bus.mdu_rd, data: bus.mdu_data};

   wbq_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .enq       (enq),
      .enq_ent   (enq_ent),
      .deq       (gnt_head),
      .inv_en    (gnt_pipe),
      .inv_rd    (bus.pipe_rd),
      .q_addr    (bus.q_addr),
      .q_hit     (q_hit),
      .head      (head),
      .head_inv  (head_inv),
      .count     (count),
      .empty_nxt (empty_nxt)
   );

   always_comb begin
      gnt_pipe = 1'b0;
      gnt_head = 1'b0;
      priority case (1'b1)
         stall:   gnt_head = head_v;
         pipe_v:  gnt_pipe = 1'b1;
         default: gnt_head = head_v;
      endcase
      rf_we_d = gnt_pipe || gnt_head;
      rf_wa_d = '0;
      rf_wd_d = '0;
      if (gnt_pipe) begin
         rf_wa_d = bus.pipe_rd;
         rf_wd_d = bus.pipe_data;
      end else if (gnt_head) begin
         rf_wa_d = head.rd;
         rf_wd_d = head.data;
      end
   end

   always_comb begin
      age_d = age_q;
      if (gnt_head || head_inv) age_d = '0;
      else if (state_q == ST_WAIT && head_v)
         age_d = (age_q >= LIM3) ? LIM3 : age_q + 3'd1;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!empty_nxt) state_d = ST_WAIT;
         ST_WAIT: begin
            if (empty_nxt)          state_d = ST_IDLE;
            else if (age_d == LIM3) state_d = ST_FORCE;
         end
         ST_FORCE: state_d = empty_nxt ? ST_IDLE : ST_WAIT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         age_q   <= '0;
         rf_we_q <= 1'b0;
         rf_wa_q <= '0;
         rf_wd_q <= '0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
         rf_we_q <= rf_we_d;
         rf_wa_q <= rf_wa_d;
         rf_wd_q <= rf_wd_d;
      end
   end

   assign bus.mdu_ready = mdu_ready;
   assign bus.q_hit     = q_hit;
   assign bus.stall     = stall;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wa     = rf_wa_q;
   assign bus.rf_wd     = rf_wd_q;

endmodule
